// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with branch resolution and retired-instruction counter
module mips_multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 halt,
  output logic                 pc_write,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 ext_sel,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [3:0]           alu_control,
  output logic [1:0]           pc_src,
  output logic                 illegal_op,
  output logic [3:0]           count_state,
  output logic [CNT_WIDTH-1:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK} state_t;
  state_t state, next;
  logic r_type, shift, r_ok, is_addi, is_andi, is_ori, is_lui, is_lw, is_sw, is_beq, is_bne, is_j, is_br, legal;
  logic [3:0] r_alu;
  assign r_type  = opcode == 6'h00;
  assign shift   = r_type && (funct == 6'h00 || funct == 6'h02);
  assign r_ok    = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
  assign is_addi = opcode == 6'h08;
  assign is_andi = opcode == 6'h0C;
  assign is_ori  = opcode == 6'h0D;
  assign is_lui  = opcode == 6'h0F;
  assign is_lw   = opcode == 6'h23;
  assign is_sw   = opcode == 6'h2B;
  assign is_beq  = opcode == 6'h04;
  assign is_bne  = opcode == 6'h05;
  assign is_j    = opcode == 6'h02;
  assign is_br   = is_beq || is_bne;
  assign legal   = r_type ? r_ok : (is_addi || is_andi || is_ori || is_lui || is_lw || is_sw || is_br || is_j);
  assign r_alu   = funct == 6'h22 ? 4'd1 : funct == 6'h24 ? 4'd2 : funct == 6'h25 ? 4'd3 :
                   funct == 6'h2A ? 4'd4 : funct == 6'h00 ? 4'd5 : funct == 6'h02 ? 4'd6 : 4'd0;
  assign count_state = {1'b0, state};
  // state register and retired-instruction counter; an instruction retires when WRITEBACK is left
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      instr_count <= '0;
    end else begin
      state <= next;
      if (state == WRITEBACK) instr_count <= instr_count + 1'b1;
    end
  end
  // next-state and datapath control decode; reset forces every strobe and select low
  always_comb begin
    next        = state;
    pc_write    = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    ext_sel     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 4'd0;
    pc_src      = 2'b00;
    illegal_op  = 1'b0;
    case (state)
      IDLE: next = halt ? IDLE : FETCH;
      FETCH: begin
        next      = DECODE;
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      DECODE: begin
        next      = EXECUTE;
        alu_src_b = 2'b11;
      end
      EXECUTE: begin
        next       = WRITEBACK;
        illegal_op = !legal;
        if (legal) begin
          alu_src_a   = shift ? 2'b10 : (is_lui || is_j) ? 2'b00 : 2'b01;
          alu_src_b   = (r_type || is_br || is_j) ? 2'b00 : 2'b10;
          alu_control = r_type ? r_alu : is_andi ? 4'd2 : is_ori ? 4'd3 : is_lui ? 4'd7 : is_br ? 4'd1 : 4'd0;
          ext_sel     = is_andi || is_ori;
          pc_src      = is_br ? 2'b01 : is_j ? 2'b10 : 2'b00;
          pc_write    = (is_beq && zero) || (is_bne && !zero) || is_j;
        end
      end
      WRITEBACK: begin
        next = halt ? IDLE : FETCH;
        if (legal) begin
          reg_write  = r_type || is_addi || is_andi || is_ori || is_lui || is_lw;
          reg_dst    = r_type;
          i_or_d     = is_lw || is_sw;
          mem_read   = is_lw;
          mem_to_reg = is_lw;
          mem_write  = is_sw;
        end
      end
      default: next = IDLE;
    endcase
    if (reset) begin
      next        = IDLE;
      pc_write    = 1'b0;
      i_or_d      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      ext_sel     = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = 4'd0;
      pc_src      = 2'b00;
      illegal_op  = 1'b0;
    end
  end
endmodule
